// File: rtl/logicalstep_pio_pkg.sv
// Shared definitions for the LogicalStep output PIO with pulse mode:
// register addresses, STATUS bit positions and the pulse timer state type.
package logicalstep_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_PULSE_MASK = 3'd1;
    localparam logic [2:0] ADDR_PULSE_LEN  = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
    localparam logic [2:0] ADDR_OUTTOGGLE  = 3'd6;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/logicalstep_pio_pulse_timer.sv
// Shared pulse-length timer for the output PIO.
// A load (re)starts the count from len; expire is high during the last
// counted cycle so the parent clears pulsed bits on that same edge.
//
// state | meaning
// IDLE  | no pulse in flight, counter parked at 0
// RUN   | pulse in flight, counter holds cycles remaining
module logicalstep_pio_pulse_timer
    import logicalstep_pio_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 expire,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    pulse_state_t         state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 last_q;
    logic [CNT_WIDTH-1:0] cnt_dec;

    assign cnt_dec = cnt_q - CNT_ONE;

    // Counter and FSM; last_q tracks cnt_q == 1 so expire comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= RUN;
                        cnt_q   <= len;
                        last_q  <= (len == CNT_ONE);
                    end
                end
                RUN: begin
                    if (load) begin
                        cnt_q  <= len;
                        last_q <= (len == CNT_ONE);
                    end else if (last_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_dec;
                        last_q <= (cnt_dec == CNT_ONE);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign expire = last_q;
    assign busy   = (state_q == RUN);

endmodule

// File: rtl/logicalstep_pio_out_pulse.sv
// Avalon-MM output PIO with set/clear/toggle aliases and a hardware pulse
// mode: masked bits that get driven high fall back to 0 after PULSE_LEN clocks.
// Optional macro PIO_OUT_IRQ_EN adds a sticky done flag and the irq output.
module logicalstep_pio_out_pulse
    import logicalstep_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH        = 8,
    parameter int                    CNT_WIDTH         = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0,
    parameter int                    PULSE_LEN_DEFAULT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
`ifdef PIO_OUT_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  trigger;
    logic                  load;
    logic                  expire;
    logic                  busy;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Next output value: expiry clear first, then the bus write on top of it.
    always_comb begin
        base    = expire ? (data_q & ~mask_q) : data_q;
        data_d  = base;
        trigger = 1'b0;
        if (wr) begin
            case (address)
                ADDR_DATA: begin
                    data_d  = wd;
                    trigger = |(wd & mask_q);
                end
                ADDR_OUTSET: begin
                    data_d  = base | wd;
                    trigger = |(wd & mask_q);
                end
                ADDR_OUTCLEAR: begin
                    data_d  = base & ~wd;
                end
                ADDR_OUTTOGGLE: begin
                    data_d  = base ^ wd;
                    trigger = |(wd & ~base & mask_q);
                end
                default: ;
            endcase
        end
        load = trigger & (len_q != '0);
    end

    // Output, mask and pulse-length registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            len_q  <= CNT_WIDTH'(PULSE_LEN_DEFAULT);
        end else begin
            data_q <= data_d;
            if (wr && address == ADDR_PULSE_MASK) mask_q <= wd;
            if (wr && address == ADDR_PULSE_LEN)  len_q  <= writedata[CNT_WIDTH-1:0];
        end
    end

    logicalstep_pio_pulse_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .len    (len_q),
        .expire (expire),
        .busy   (busy)
    );

`ifdef PIO_OUT_IRQ_EN
    logic done_q;

    // Sticky done: set on an expiry not swallowed by a reload; set beats a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else if (expire && !load) begin
            done_q <= 1'b1;
        end else if (wr && address == ADDR_STATUS && writedata[STATUS_DONE_BIT]) begin
            done_q <= 1'b0;
        end
    end

    assign irq = done_q;
`endif

    // Zero-extended, zero-latency register readback.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata = 32'(data_q);
            ADDR_PULSE_MASK: readdata = 32'(mask_q);
            ADDR_PULSE_LEN:  readdata = 32'(len_q);
            ADDR_STATUS: begin
                readdata[STATUS_BUSY_BIT] = busy;
`ifdef PIO_OUT_IRQ_EN
                readdata[STATUS_DONE_BIT] = done_q;
`endif
            end
            default: ;
        endcase
    end

    assign out_port = data_q;

endmodule

// File: tb/tb_logicalstep_pio_out_pulse.sv
// Testbench for logicalstep_pio_out_pulse (DATA_WIDTH=8, RESET_VALUE=8'hA5).
// Optional macro PIO_OUT_IRQ_EN enables the irq checks.
module tb_logicalstep_pio_out_pulse;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
`ifdef PIO_OUT_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    logicalstep_pio_out_pulse #(
        .DATA_WIDTH(8),
        .CNT_WIDTH(16),
        .RESET_VALUE(RV),
        .PULSE_LEN_DEFAULT(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
`ifdef PIO_OUT_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pulse is a deadline (edge index) at which masked bits drop.
    logic [7:0]  m_data, m_mask;
    logic [15:0] m_len;
    longint      m_deadline = -1;
    longint      cyc = 0;
    bit          m_done = 0;
    bit          started = 0;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r = {24'd0, m_data};
            3'd1: r = {24'd0, m_mask};
            3'd2: r = {16'd0, m_len};
            3'd3: begin
                r[0] = (m_deadline > cyc);
`ifdef PIO_OUT_IRQ_EN
                r[1] = m_done;
`endif
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        logic [7:0] base, wd, nd;
        bit ex, trig, ld, wr_en;
        cyc = cyc + 1;
        if (!reset_n) begin
            m_data = RV; m_mask = 8'h00; m_len = 16'd1;
            m_deadline = -1; m_done = 0; started = 1;
        end else if (started) begin
            wr_en = chipselect && !write_n;
            wd    = writedata[7:0];
            ex    = (m_deadline == cyc);
            base  = ex ? (m_data & ~m_mask) : m_data;
            nd    = base;
            trig  = 0;
            if (wr_en) begin
                case (address)
                    3'd0: begin nd = wd;         trig = (wd & m_mask) != 0; end
                    3'd4: begin nd = base | wd;  trig = (wd & m_mask) != 0; end
                    3'd5: begin nd = base & ~wd; end
                    3'd6: begin nd = base ^ wd;  trig = (nd & ~base & m_mask) != 0; end
                    default: ;
                endcase
            end
            ld = trig && (m_len != 0);
            if (ld) m_deadline = cyc + m_len;
            if (wr_en && address == 3'd3 && writedata[1]) m_done = 0;
            if (ex && !ld) m_done = 1;
            if (wr_en && address == 3'd1) m_mask = wd;
            if (wr_en && address == 3'd2) m_len = writedata[15:0];
            m_data = nd;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started && reset_n) begin
            chk("out_port", {24'd0, out_port}, {24'd0, m_data});
            chk("readdata", readdata, m_read(address));
`ifdef PIO_OUT_IRQ_EN
            chk("irq", {31'd0, irq}, {31'd0, m_done});
`endif
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        #1;
        chk(name, readdata, exp);
        @(posedge clk); #2;
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 32'd0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        rd_chk("rst_data",   3'd0, 32'h0000_00A5);
        rd_chk("rst_mask",   3'd1, 32'h0);
        rd_chk("rst_len",    3'd2, 32'h1);
        rd_chk("rst_status", 3'd3, 32'h0);

        wr(3'd0, 32'h0F); wr(3'd4, 32'h30); wr(3'd5, 32'h03); wr(3'd6, 32'hFF);
        chk("basic_out", {24'd0, out_port}, 32'hC3);
        rd_chk("basic_rd", 3'd0, 32'hC3);
        rd_chk("rd_addr4", 3'd4, 32'h0);

        // Single 5-cycle pulse on bit0.
        wr(3'd1, 32'h01); wr(3'd2, 32'd5); wr(3'd4, 32'h01);
        for (int i = 0; i < 7; i++) begin
            address = 3'd3;
            #1;
            chk("pulse_bit0",  {31'd0, out_port[0]}, (i < 5) ? 32'd1 : 32'd0);
            chk("pulse_busy",  {31'd0, readdata[0]}, (i < 5) ? 32'd1 : 32'd0);
            chk("pulse_other", {25'd0, out_port[7:1]}, 32'h61);
            @(posedge clk); #2;
        end

        // Retrigger mid-pulse, then again exactly on the expiry edge.
        wr(3'd4, 32'h01); idle(2); wr(3'd4, 32'h01); idle(4);
        chk("retrig_hold", {31'd0, out_port[0]}, 32'd1);
        wr(3'd4, 32'h01);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("reload_bit0", {31'd0, out_port[0]}, (i < 5) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end

        // Toggle trigger, mask shrink and OUTCLEAR while running.
        wr(3'd2, 32'd4); wr(3'd1, 32'h0F); wr(3'd0, 32'h50);
        wr(3'd6, 32'h03); wr(3'd1, 32'h01); wr(3'd5, 32'h02); idle(3);
        chk("mix_out", {24'd0, out_port}, 32'h50);

        // Pulse mode off with PULSE_LEN=0.
        wr(3'd3, 32'h2);
        wr(3'd2, 32'd0); wr(3'd1, 32'hFF); wr(3'd0, 32'hFF); idle(20);
        chk("len0_out", {24'd0, out_port}, 32'hFF);
        rd_chk("len0_status", 3'd3, 32'h0);

        // Reset mid-pulse aborts it.
        wr(3'd2, 32'd5); wr(3'd1, 32'h01); wr(3'd4, 32'h01); idle(2);
        reset_n = 1'b0;
        @(posedge clk); #2;
        chk("rst_mid_out", {24'd0, out_port}, 32'hA5);
        reset_n = 1'b1;
        rd_chk("rst_mid_status", 3'd3, 32'h0);

        // Done flag / irq.
        wr(3'd1, 32'h01); wr(3'd2, 32'd3); wr(3'd4, 32'h01); idle(4);
`ifdef PIO_OUT_IRQ_EN
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd_chk("irq_status", 3'd3, 32'h2);
`else
        rd_chk("irq_status", 3'd3, 32'h0);
`endif
        wr(3'd3, 32'h2);
`ifdef PIO_OUT_IRQ_EN
        chk("irq_clear", {31'd0, irq}, 32'd0);
`endif
        wr(3'd4, 32'h01); idle(2); wr(3'd3, 32'h2);
`ifdef PIO_OUT_IRQ_EN
        chk("irq_setwins", {31'd0, irq}, 32'd1);
`endif
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
